// File: rtl/pe_pkg.sv
// Shared constants and types for the PE array datapath blocks.
package pe_pkg;

   // Default width of one lane of a PE operand bus.
   localparam int LANE_W = 16;

   // Default number of lanes carried by one operand bus.
   localparam int PE_LANES = 4;

   // Default skew depth used by the delay lines feeding the PE columns.
   localparam int PE_SKEW_DEPTH = 4;

   // Lane-indexed view of a flat operand bus: element i is bits [i*LANE_W +: LANE_W].
   typedef logic [PE_LANES-1:0][LANE_W-1:0] lanes_t;

endpackage

// File: rtl/pe_delay_stage.sv
// One register stage of the PE delay line: a valid bit plus a full lane bundle.
// Invalid beats are stored as all-zero data so downstream adders need no gating.
module pe_delay_stage
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = LANE_W,
   parameter int LANES      = PE_LANES
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        flush,
   input  logic                        ena,
   input  logic                        in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   output logic                        out_valid,
   output logic [LANES*DATA_WIDTH-1:0] out_data
);

   logic                        valid_d, valid_q;
   logic [LANES*DATA_WIDTH-1:0] data_d,  data_q;

   // Next stage contents: flush clears, enable loads (zeroing invalid data), otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (flush) begin
         valid_d = 1'b0;
         data_d  = '0;
      end else if (ena) begin
         valid_d = in_valid;
         data_d  = in_valid ? in_data : '0;
      end
   end

   // Stage register with synchronous reset taking priority over everything else.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/pe_delay_line.sv
// Multi-lane, multi-stage delay line with stall, flush, run-time tap select
// and an in-flight beat counter. Used to skew operand buses into the PE columns.
module pe_delay_line
   import pe_pkg::*;
#(
   parameter int DATA_WIDTH = LANE_W,
   parameter int LANES      = PE_LANES,
   parameter int DEPTH      = PE_SKEW_DEPTH,
   parameter int TAP_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int CNT_W      = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        ena,
   input  logic                        flush,
   input  logic                        in_valid,
   input  logic [LANES*DATA_WIDTH-1:0] in_data,
   input  logic [TAP_W-1:0]            tap_sel,
   output logic                        out_valid,
   output logic [LANES*DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]            occupancy
);

   localparam int BUS_W = LANES * DATA_WIDTH;

   logic [DEPTH-1:0] v;
   logic [BUS_W-1:0] d [DEPTH];
   logic [CNT_W-1:0] occ_d, occ_q;
   logic [31:0]      tap_idx;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             stage_in_valid;
      logic [BUS_W-1:0] stage_in_data;

      if (k == 0) begin : g_head
         assign stage_in_valid = in_valid;
         assign stage_in_data  = in_data;
      end else begin : g_body
         assign stage_in_valid = v[k-1];
         assign stage_in_data  = d[k-1];
      end

      pe_delay_stage #(
         .DATA_WIDTH (DATA_WIDTH),
         .LANES      (LANES)
      ) u_stage (
         .clk       (clk),
         .rst       (rst),
         .flush     (flush),
         .ena       (ena),
         .in_valid  (stage_in_valid),
         .in_data   (stage_in_data),
         .out_valid (v[k]),
         .out_data  (d[k])
      );
   end

   // Output tap: clamp out-of-range selects to the last stage, then pick that stage.
   always_comb begin
      tap_idx   = 32'(tap_sel);
      if (tap_idx > 32'(DEPTH - 1)) begin
         tap_idx = 32'(DEPTH - 1);
      end
      out_valid = v[0];
      out_data  = d[0];
      for (int k = 1; k < DEPTH; k++) begin
         if (tap_idx == 32'(k)) begin
            out_valid = v[k];
            out_data  = d[k];
         end
      end
   end

   // In-flight count: a beat enters with in_valid and leaves when the last stage shifts out.
   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (ena) begin
         occ_d = occ_q + CNT_W'(in_valid) - CNT_W'(v[DEPTH-1]);
      end
   end

   // Occupancy register, cleared by synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_pe_delay_line.sv
// Scoreboard bench for pe_delay_line (DEPTH=4), with DEPTH=3 and DEPTH=1
// side instances sharing the same stimulus for tap clamping checks.
module tb_pe_delay_line;

   typedef struct {
      logic [63:0] data;
      int          due;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        ena;
   logic        flush;
   logic        in_valid;
   logic [63:0] in_data;
   logic [1:0]  tap_sel;

   logic        out_valid;
   logic [63:0] out_data;
   logic [2:0]  occupancy;

   logic        u3_out_valid;
   logic [63:0] u3_out_data;
   logic [1:0]  u3_occupancy;
   logic        u1_out_valid;
   logic [63:0] u1_out_data;
   logic        u1_occupancy;

   int vectors    = 0;
   int miscompares = 0;

   item_t sb[$];
   int    acc[$];
   int    edge_cnt = 0;
   int    evt_cnt  = 0;

   pe_delay_line #(.DATA_WIDTH(16), .LANES(4), .DEPTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .tap_sel   (tap_sel),
      .out_valid (out_valid),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   pe_delay_line #(.DATA_WIDTH(16), .LANES(4), .DEPTH(3)) u3 (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .tap_sel   (tap_sel),
      .out_valid (u3_out_valid),
      .out_data  (u3_out_data),
      .occupancy (u3_occupancy)
   );

   pe_delay_line #(.DATA_WIDTH(16), .LANES(4), .DEPTH(1)) u1 (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .tap_sel   (tap_sel[0]),
      .out_valid (u1_out_valid),
      .out_data  (u1_out_data),
      .occupancy (u1_occupancy)
   );

   // Free-running clock.
   initial forever #5 clk = ~clk;

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Scoreboard producer: records every beat the DUT should accept, with its due edge.
   initial forever begin
      @(posedge clk);
      if (rst || flush) begin
         sb.delete();
         acc.delete();
         evt_cnt++;
      end else if (ena) begin
         edge_cnt++;
         evt_cnt++;
         if (in_valid) begin
            sb.push_back('{data: in_data, due: edge_cnt + int'(tap_sel)});
            acc.push_back(edge_cnt);
         end
      end
   end

   // Monitor: on each updating edge pop/compare outputs; on stalled edges require frozen outputs.
   initial begin
      int          last_evt;
      logic        prev_valid;
      logic [63:0] prev_data;
      logic [2:0]  prev_occ;
      logic        exp_valid;
      item_t       it;
      last_evt   = 0;
      prev_valid = 1'b0;
      prev_data  = '0;
      prev_occ   = '0;
      forever begin
         @(negedge clk);
         if (evt_cnt != last_evt) begin
            last_evt  = evt_cnt;
            exp_valid = (sb.size() > 0) && (sb[0].due == edge_cnt);
            vectors++;
            if (out_valid !== exp_valid) begin
               miscompares++;
               $display("[TB] FAIL out_valid edge=%0d: actual=%b required=%b", edge_cnt, out_valid, exp_valid);
            end
            if (exp_valid) begin
               it = sb.pop_front();
               vectors++;
               if (out_data !== it.data) begin
                  miscompares++;
                  $display("[TB] FAIL out_data edge=%0d: actual=%h required=%h", edge_cnt, out_data, it.data);
               end
            end else begin
               vectors++;
               if (out_data !== 64'h0) begin
                  miscompares++;
                  $display("[TB] FAIL zero_data edge=%0d: actual=%h required=0", edge_cnt, out_data);
               end
            end
            while (acc.size() > 0 && (edge_cnt - acc[0]) >= 4) begin
               void'(acc.pop_front());
            end
            vectors++;
            if (occupancy !== 3'(acc.size())) begin
               miscompares++;
               $display("[TB] FAIL occupancy edge=%0d: actual=%0d required=%0d", edge_cnt, occupancy, acc.size());
            end
         end else begin
            vectors++;
            if (out_valid !== prev_valid || out_data !== prev_data || occupancy !== prev_occ) begin
               miscompares++;
               $display("[TB] FAIL stall_frozen: actual=%b/%h/%0d required=%b/%h/%0d",
                        out_valid, out_data, occupancy, prev_valid, prev_data, prev_occ);
            end
         end
         prev_valid = out_valid;
         prev_data  = out_data;
         prev_occ   = occupancy;
      end
   end

   // Drive one cycle of inputs just after a rising edge.
   task automatic apply_stimulus(input logic v, input logic [63:0] dat, input logic e,
                                 input logic f, input logic r);
      @(posedge clk);
      #1;
      in_valid = v;
      in_data  = dat;
      ena      = e;
      flush    = f;
      rst      = r;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
   endtask

   // Direct check of the side instances.
   task automatic check_output(input string name, input logic act_v, input logic exp_v,
                               input logic [63:0] act_d, input logic [63:0] exp_d);
      vectors++;
      if (act_v !== exp_v || act_d !== exp_d) begin
         miscompares++;
         $display("[TB] FAIL %s: actual=%b/%h required=%b/%h", name, act_v, act_d, exp_v, exp_d);
      end
   endtask

   initial begin
      rst      = 1'b1;
      ena      = 1'b1;
      flush    = 1'b0;
      tap_sel  = 2'd0;
      in_valid = 1'($urandom_range(1));
      in_data  = {$urandom, $urandom};

      // Reset with random inputs for two edges.
      apply_stimulus(1'($urandom_range(1)), {$urandom, $urandom}, 1'($urandom_range(1)), 1'b0, 1'b1);
      apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
      idle(2);

      // Latency sweep over every tap.
      for (int t = 0; t < 4; t++) begin
         tap_sel = 2'(t);
         apply_stimulus(1'b1, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b0);
         idle(6);
      end

      // Stall with a valid beat sitting on the output; stalled in_valid must be dropped.
      tap_sel = 2'd3;
      apply_stimulus(1'b1, 64'h1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h2, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h3, 1'b1, 1'b0, 1'b0);
      idle(1);
      for (int i = 0; i < 5; i++) apply_stimulus(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
      idle(6);

      // Fill to four beats, then flush together with a new beat.
      apply_stimulus(1'b1, 64'hA1, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'hA2, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'hA3, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'hA4, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'hBEEF, 1'b1, 1'b1, 1'b0);
      idle(6);

      // Alternating valid/invalid beats; invalid beats carry all-ones that must not leak.
      tap_sel = 2'd1;
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) apply_stimulus(1'b1, 64'hA5A5_0000_0000_0000 | 64'(i), 1'b1, 1'b0, 1'b0);
         else            apply_stimulus(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
      end
      idle(6);

      // Clamping: tap 3 on DEPTH=3 gives delay 3; DEPTH=1 always gives delay 1.
      tap_sel = 2'd3;
      apply_stimulus(1'b1, 64'hC0DE_0000_0000_1234, 1'b1, 1'b0, 1'b0);
      for (int c = 1; c <= 4; c++) begin
         idle(1);
         check_output($sformatf("clamp_d3_c%0d", c), u3_out_valid, (c == 3),
                      u3_out_data, (c == 3) ? 64'hC0DE_0000_0000_1234 : 64'h0);
         check_output($sformatf("clamp_d1_c%0d", c), u1_out_valid, (c == 1),
                      u1_out_data, (c == 1) ? 64'hC0DE_0000_0000_1234 : 64'h0);
      end
      idle(3);

      // Reset mid-stream behaves like flush.
      apply_stimulus(1'b1, 64'h51, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h52, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 64'h53, 1'b1, 1'b0, 1'b1);
      idle(6);

      @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: actual=%0d pending required=0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pe_delay_line.md
# pe_delay_line

Parametrised multi-lane, multi-stage delay line for the PE array. It replaces single-stage enabled registers wherever operands or partial sums must be skewed by more than one cycle. It carries a valid bit alongside each beat, supports a global stall (`ena`), a synchronous flush, a run-time tap select for the effective delay, and reports how many valid beats are in flight. It sits between the feeder/skew logic and the PE columns, one instance per skewed operand bus.

## Interface
- `DATA_WIDTH`, 16: width of one lane in bits.
- `LANES`, 4: number of parallel lanes shifted together.
- `DEPTH`, 4: number of register stages (≥1); maximum delay in enabled cycles.
- `TAP_W`, `$clog2(DEPTH)` (minimum 1): width of `tap_sel`.
- `CNT_W`, `$clog2(DEPTH+1)`: width of `occupancy`.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset: synchronous, active-high.
- `ena`  in  1  shift enable (stall when low).
- `flush`  in  1  synchronous clear of all stages.
- `in_valid`  in  1  beat on `in_data` is valid.
- `in_data`  in  LANES*DATA_WIDTH  lane `i` occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `tap_sel`  in  TAP_W  selects output stage; effective delay is `tap_sel+1` enabled cycles.
- `out_valid`  out  1  valid bit of the selected stage.
- `out_data`  out  LANES*DATA_WIDTH  data of the selected stage; all zero when `out_valid`=0.
- `occupancy`  out  CNT_W  number of valid beats in stages 0..DEPTH-1.

## Operation
- Stage k holds `{v[k], d[k]}`. On an enabled cycle:
  - stage 0 loads `{in_valid, in_valid ? in_data : 0}`;
  - stage k loads stage k-1 for k≥1;
  - stage DEPTH-1 contents are discarded.
- `ena`=0: every stage holds. Inputs are ignored; `in_valid` high while stalled is dropped, and the upstream sender must hold the beat.
- Invalid beats always carry zero data, so downstream accumulators can add `out_data` unconditionally.
- Output mux: `out_valid = v[t]`, `out_data = d[t]`, where `t = min(tap_sel, DEPTH-1)`. Out-of-range `tap_sel` is clamped, never X.
- Changing `tap_sel` takes effect in the same cycle, as a combinational mux from registers. Beats already past the new tap are not re-emitted. Beats before the new tap emerge later. The caller changes `tap_sel` only when `occupancy`=0 if ordering matters.
- `occupancy` is a registered counter:
  - on an enabled cycle: next = cur + in_valid − v[DEPTH-1];
  - on a stalled cycle: held;
  - never exceeds DEPTH and never underflows.
- Priority: `rst` > `flush` > `ena`. Both `rst` and `flush` clear all `v`, all `d`, and `occupancy` to 0 on the next edge, regardless of `ena`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `occupancy`=0, all stages zero.
- Latency: a beat accepted at edge N (`ena`=1) appears at the output after edge N+`tap_sel`, counting enabled edges only. With `tap_sel`=0 it is visible the cycle after acceptance.
- Stall mid-stream: outputs frozen for the full stall and resume with no beat lost or duplicated.
- Flush and `in_valid` in the same cycle: the incoming beat is discarded; occupancy is 0 afterwards.
- Reset mid-operation is identical to flush.
- DEPTH=1: `tap_sel` is ignored (treated as 0) and the block behaves as one enabled register plus a valid bit.
- `tap_sel` to output is a combinational path. All other outputs come directly from registers.

## Structure
- Shared package `pe_pkg`: lane slice helper constant `LANE_W`, a default `PE_SKEW_DEPTH`, and the `lanes_t` packed-array typedef `logic [LANES-1:0][DATA_WIDTH-1:0]` used for `in_data`/`out_data` reinterpretation.
- Sub-module `pe_delay_stage`: one stage (valid bit plus LANES×DATA_WIDTH data, with rst/flush/ena priority and zero-on-invalid). Instantiated DEPTH times in a generate loop.
- Top level: stage chain, clamped output mux, occupancy counter.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs → `out_valid`=0, `out_data`=0, `occupancy`=0 every cycle while asserted and one cycle after.
- Latency sweep: DEPTH=4; for `tap_sel`=0..3, send one beat `0x1111_2222_3333_4444` with `ena`=1 → it appears exactly `tap_sel`+1 cycles later for one cycle; `occupancy` goes to 1 and back to 0 after 4 cycles.
- Stall: stream 0x1,0x2,0x3 with `tap_sel`=3, drop `ena` for 5 cycles mid-stream → outputs frozen during the stall; the output sequence is 0x1,0x2,0x3 with no gaps between enabled cycles and no duplicates.
- Flush collision: pipeline full (occupancy=4), assert `flush` with `in_valid`=1 and `ena`=1 → next cycle occupancy=0, `out_valid`=0; the new beat never appears.
- Bubbles and zero data: send a valid/invalid alternating pattern with `in_data`=0xFFFF when invalid → invalid outputs read 0; occupancy oscillates 2↔2 in steady state with DEPTH=4.
- Clamp: DEPTH=3, `tap_sel`=3 → behaves as `tap_sel`=2 (delay 3). DEPTH=1 → delay 1, behaves as an enabled register.
